// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the slave memory model.
// Contents: burst/response encodings, FSM state types, address-step,
//           range-decode and burst-legality helpers used by both channel FSMs.
package axi_pkg;

  // Helpers work on a fixed wide address; callers zero-extend/truncate.
  localparam int AXI_MAX_AW = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

  // Address of the beat following 'addr' within a burst.
  function automatic logic [AXI_MAX_AW-1:0] next_addr(
    input logic [AXI_MAX_AW-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [AXI_MAX_AW-1:0] b;
    logic [AXI_MAX_AW-1:0] w;
    b = AXI_MAX_AW'(1) << size;
    w = (AXI_MAX_AW'(len) + AXI_MAX_AW'(1)) << size;
    case (burst)
      BURST_INCR: next_addr = (addr & ~(b - AXI_MAX_AW'(1))) + b;
      BURST_WRAP: next_addr = (addr & ~(w - AXI_MAX_AW'(1))) | ((addr + b) & (w - AXI_MAX_AW'(1)));
      default:    next_addr = addr;
    endcase
  endfunction

  function automatic logic in_range(
    input logic [AXI_MAX_AW-1:0] addr,
    input logic [AXI_MAX_AW-1:0] base,
    input logic [AXI_MAX_AW-1:0] span
  );
    return (addr >= base) && ((addr - base) < span);
  endfunction

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // True when an INCR burst's first and last byte sit in different 4KB pages.
  function automatic logic crosses_4k(
    input logic [AXI_MAX_AW-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len
  );
    logic [AXI_MAX_AW-1:0] b;
    logic [AXI_MAX_AW-1:0] last_byte;
    b         = AXI_MAX_AW'(1) << size;
    last_byte = (addr & ~(b - AXI_MAX_AW'(1))) + ((AXI_MAX_AW'(len) + AXI_MAX_AW'(1)) << size)
                - AXI_MAX_AW'(1);
    return (addr >> 12) != (last_byte >> 12);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Latched burst context: holds id/addr/len/size/burst, steps the beat address
// and reports last-beat and per-beat SLVERR. LOOKAHEAD=1 exposes the values the
// registers will hold after this edge (read side prefetch), 0 the current ones.
// Ports: clk/rst, load (address handshake) + in_* burst fields, adv (data beat),
//        id_o/addr_o/last_o/err_o beat view, in_cross_4k for the loading burst.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                LOOKAHEAD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [ID_W-1:0]   in_id,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_len,
  input  logic [2:0]        in_size,
  input  logic [1:0]        in_burst,
  output logic [ID_W-1:0]   id_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              err_o,
  output logic              in_cross_4k
);

  localparam logic [2:0]            MAX_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [AXI_MAX_AW-1:0] SPAN     = AXI_MAX_AW'(DEPTH) * AXI_MAX_AW'(DATA_W / 8);
  localparam logic [AXI_MAX_AW-1:0] BASE_EXT = AXI_MAX_AW'(BASE_ADDR);

  logic [ID_W-1:0]   id_q,    id_n;
  logic [ADDR_W-1:0] addr_q,  addr_n;
  logic [7:0]        len_q,   len_n;
  logic [2:0]        size_q,  size_n;
  logic [1:0]        burst_q, burst_n;
  logic [7:0]        beat_q,  beat_n;
  logic              bad_q,   bad_n;
  logic              in_bad;

  // Illegal burst shapes poison every beat of the burst.
  always_comb begin
    in_bad = (in_size > MAX_SIZE) || (in_burst == 2'b11) ||
             ((in_burst == BURST_WRAP) && !wrap_len_ok(in_len));
  end

  always_comb begin
    in_cross_4k = (in_burst == BURST_INCR) && crosses_4k(AXI_MAX_AW'(in_addr), in_size, in_len);
  end

  always_comb begin
    id_n    = id_q;
    addr_n  = addr_q;
    len_n   = len_q;
    size_n  = size_q;
    burst_n = burst_q;
    beat_n  = beat_q;
    bad_n   = bad_q;
    if (load) begin
      id_n    = in_id;
      addr_n  = in_addr;
      len_n   = in_len;
      size_n  = in_size;
      burst_n = in_burst;
      beat_n  = '0;
      bad_n   = in_bad;
    end else if (adv) begin
      addr_n = ADDR_W'(next_addr(AXI_MAX_AW'(addr_q), size_q, len_q, burst_q));
      beat_n = beat_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      bad_q   <= 1'b0;
    end else begin
      id_q    <= id_n;
      addr_q  <= addr_n;
      len_q   <= len_n;
      size_q  <= size_n;
      burst_q <= burst_n;
      beat_q  <= beat_n;
      bad_q   <= bad_n;
    end
  end

  always_comb begin
    if (LOOKAHEAD) begin
      id_o   = id_n;
      addr_o = addr_n;
      last_o = (beat_n == len_n);
      err_o  = bad_n || !in_range(AXI_MAX_AW'(addr_n), BASE_EXT, SPAN);
    end else begin
      id_o   = id_q;
      addr_o = addr_q;
      last_o = (beat_q == len_q);
      err_o  = bad_q || !in_range(AXI_MAX_AW'(addr_q), BASE_EXT, SPAN);
    end
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4-full slave memory: independent write (AW/W/B) and read (AR/R) engines,
// one outstanding burst each, FIXED/INCR/WRAP, byte strobes, SLVERR decode,
// RD_WAIT idle cycles before each R beat and a sticky protocol-error flag.
// Ports: aclk/areset (sync, active high); AW, W, B, AR, R channels; proto_err.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_WAIT   = 0
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output logic                proto_err
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam int         BSHIFT    = $clog2(STRB_W);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write side ----------------
  wstate_e           w_state, w_next;
  logic              aw_hs, w_hs;
  logic              w_err;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic              w_last, w_beat_err, aw_cross;
  logic [IDX_W-1:0]  w_idx;

  axi_burst_addr #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b0)
  ) u_wr_burst (
    .clk(aclk), .rst(areset), .load(aw_hs), .adv(w_hs),
    .in_id(awid), .in_addr(awaddr), .in_len(awlen), .in_size(awsize), .in_burst(awburst),
    .id_o(w_id), .addr_o(w_addr), .last_o(w_last), .err_o(w_beat_err),
    .in_cross_4k(aw_cross)
  );

  always_comb begin
    w_idx = IDX_W'((w_addr - BASE_ADDR) >> BSHIFT);
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    aw_hs   = 1'b0;
    w_hs    = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !areset;
        aw_hs   = awvalid && !areset;
        if (aw_hs) w_next = W_DATA;
      end
      W_DATA: begin
        wready = !areset;
        w_hs   = wvalid && !areset;
        // Burst length comes from awlen; wlast is only checked, never trusted.
        if (w_hs && w_last) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_err <= 1'b0;
    end else if (aw_hs) begin
      w_err <= 1'b0;
    end else if (w_hs) begin
      w_err <= w_err | w_beat_err | (wlast != w_last);
    end
  end

  // Memory has no reset so contents survive areset.
  always_ff @(posedge aclk) begin
    if (w_hs && !w_beat_err) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    bid   = w_id;
    bresp = w_err ? RESP_SLVERR : RESP_OKAY;
  end

  // ---------------- read side ----------------
  rstate_e           r_state, r_next;
  logic              ar_hs, r_hs, fetch;
  logic [3:0]        wait_cnt;
  logic [ID_W-1:0]   r_id_d;
  logic [ADDR_W-1:0] r_addr_d;
  logic              r_last_d, r_err_d, ar_cross;
  logic [IDX_W-1:0]  r_idx_d;

  // Lookahead view: the beat the R registers will present after this edge.
  axi_burst_addr #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .BASE_ADDR(BASE_ADDR), .LOOKAHEAD(1'b1)
  ) u_rd_burst (
    .clk(aclk), .rst(areset), .load(ar_hs), .adv(r_hs),
    .in_id(arid), .in_addr(araddr), .in_len(arlen), .in_size(arsize), .in_burst(arburst),
    .id_o(r_id_d), .addr_o(r_addr_d), .last_o(r_last_d), .err_o(r_err_d),
    .in_cross_4k(ar_cross)
  );

  always_comb begin
    r_idx_d = IDX_W'((r_addr_d - BASE_ADDR) >> BSHIFT);
  end

  // 'fetch' marks every edge that enters R_DATA; the R payload is loaded then
  // and held untouched while the master stalls.
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    ar_hs   = 1'b0;
    r_hs    = 1'b0;
    fetch   = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = !areset;
        ar_hs   = arvalid && !areset;
        if (ar_hs) begin
          if (RD_WAIT == 0) begin
            r_next = R_DATA;
            fetch  = 1'b1;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          r_next = R_DATA;
          fetch  = 1'b1;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        r_hs   = rready && !areset;
        if (r_hs) begin
          if (rlast) begin
            r_next = R_IDLE;
          end else if (RD_WAIT == 0) begin
            fetch = 1'b1;
          end else begin
            r_next = R_WAIT;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_ff @(posedge aclk) begin
    if (areset || r_state != R_WAIT) wait_cnt <= '0;
    else                             wait_cnt <= wait_cnt + 4'd1;
  end

  // Reading mem here sees the pre-edge value, so a same-cycle write to the
  // same word returns old data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rid   <= '0;
      rdata <= '0;
      rresp <= RESP_OKAY;
      rlast <= 1'b0;
    end else if (fetch) begin
      rid   <= r_id_d;
      rlast <= r_last_d;
      if (r_err_d) begin
        rdata <= '0;
        rresp <= RESP_SLVERR;
      end else begin
        rdata <= mem[r_idx_d];
        rresp <= RESP_OKAY;
      end
    end
  end

  // ---------------- protocol checker ----------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      proto_err <= 1'b0;
    end else if ((aw_hs && aw_cross) || (ar_hs && ar_cross) || (w_hs && (wlast != w_last))) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem (DATA_W=32, DEPTH=1024, BASE_ADDR=0, RD_WAIT=2).
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Expected values are hand-computed constants per step.
module tb_axi_slave_mem;

  localparam int LIM = 50;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        proto_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wbuf  [16];
  logic [31:0] exp_d [16];
  logic [1:0]  exp_r [16];
  logic [3:0]  got_bid;
  logic [1:0]  got_bresp;

  always #5 aclk = ~aclk;

  axi_slave_mem #(
    .DATA_W(32), .ID_W(4), .ADDR_W(32), .DEPTH(1024), .BASE_ADDR(32'h0), .RD_WAIT(2)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int early_last,
                          output logic [3:0] o_bid, output logic [1:0] o_bresp);
    int t;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < LIM) begin @(negedge aclk); t++; end
    chk("aw_wait", t < LIM, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb;
      wlast  = (b == int'(len)) || (b == early_last);
      t = 0;
      while (!wready && t < LIM) begin @(negedge aclk); t++; end
      chk("w_wait", t < LIM, 1);
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < LIM) begin @(negedge aclk); t++; end
    chk("b_wait", t < LIM, 1);
    o_bid = bid; o_bresp = bresp;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  // Checks each beat against exp_d/exp_r, rlast placement, rid and the
  // 1+RD_WAIT cycle spacing; optionally stalls rready for 3 cycles on one beat.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat);
    int t;
    int gap;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    rready = 1'b1;
    t = 0;
    while (!arready && t < LIM) begin @(negedge aclk); t++; end
    chk("ar_wait", t < LIM, 1);
    for (int b = 0; b <= int'(len); b++) begin
      gap = 0;
      do begin
        @(negedge aclk);
        gap++;
        arvalid = 1'b0;
      end while (!rvalid && gap < LIM);
      chk($sformatf("rd_gap[%0d]", b), gap, 3);
      if (b == stall_beat) begin
        rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge aclk);
          chk($sformatf("stall_valid[%0d]", s), rvalid, 1);
          chk($sformatf("stall_data[%0d]", s), rdata, exp_d[b]);
          chk($sformatf("stall_last[%0d]", s), rlast, (b == int'(len)));
        end
        rready = 1'b1;
      end
      chk($sformatf("rd_data[%0d]", b), rdata, exp_d[b]);
      chk($sformatf("rd_resp[%0d]", b), rresp, exp_r[b]);
      chk($sformatf("rd_last[%0d]", b), rlast, (b == int'(len)));
      chk($sformatf("rd_id[%0d]", b), rid, id);
    end
    @(negedge aclk);
    rready = 1'b0;
    chk("rd_done_no_extra_beat", rvalid, 0);
  endtask

  initial begin
    int t;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset state
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_outputs", {bid, bresp, rid, rresp, rlast, proto_err}, 0);
    chk("rst_rdata", rdata, 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);

    // 1: INCR write then read back
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
    do_write(4'd5, 32'h100, 8'd3, 2'b01, 4'hF, -1, got_bid, got_bresp);
    chk("t1_bid", got_bid, 5);
    chk("t1_bresp", got_bresp, 2'b00);
    chk("t1_awready_after_b", awready, 1);
    for (int i = 0; i < 4; i++) begin exp_d[i] = 32'hA000_0000 + 32'(i); exp_r[i] = 2'b00; end
    do_read(4'd7, 32'h100, 8'd3, 2'b01, -1);

    // 2: WRAP write from 0x10C, INCR read from 0x100
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hD000_0000 + 32'(i);
    do_write(4'd2, 32'h10C, 8'd3, 2'b10, 4'hF, -1, got_bid, got_bresp);
    chk("t2_bresp", got_bresp, 2'b00);
    exp_d[0] = 32'hD000_0001; exp_d[1] = 32'hD000_0002;
    exp_d[2] = 32'hD000_0003; exp_d[3] = 32'hD000_0000;
    do_read(4'd1, 32'h100, 8'd3, 2'b01, -1);

    // 3: byte strobes
    wbuf[0] = 32'h0;
    do_write(4'd1, 32'h40, 8'd0, 2'b01, 4'hF, -1, got_bid, got_bresp);
    wbuf[0] = 32'hDEAD_BEEF;
    do_write(4'd1, 32'h40, 8'd0, 2'b01, 4'h5, -1, got_bid, got_bresp);
    chk("t3_bresp", got_bresp, 2'b00);
    exp_d[0] = 32'h00AD_00EF; exp_r[0] = 2'b00;
    do_read(4'd3, 32'h40, 8'd0, 2'b01, -1);

    // 4: decode errors
    wbuf[0] = 32'h55AA_55AA;
    do_write(4'd0, 32'hFFC, 8'd0, 2'b01, 4'hF, -1, got_bid, got_bresp);
    wbuf[0] = 32'h1111_1111;
    do_write(4'd0, 32'h0, 8'd0, 2'b01, 4'hF, -1, got_bid, got_bresp);
    wbuf[0] = 32'h9999_9999;
    do_write(4'd6, 32'h1000, 8'd0, 2'b01, 4'hF, -1, got_bid, got_bresp);
    chk("t4_oor_bresp", got_bresp, 2'b10);
    chk("t4_oor_bid", got_bid, 6);
    exp_d[0] = 32'h1111_1111; exp_r[0] = 2'b00;
    do_read(4'd0, 32'h0, 8'd0, 2'b01, -1);
    wbuf[0] = 32'hCAFE_F00D;
    do_write(4'd0, 32'h200, 8'd0, 2'b01, 4'hF, -1, got_bid, got_bresp);
    wbuf[0] = 32'h0BAD_BEEF;
    do_write(4'd0, 32'h200, 8'd0, 2'b11, 4'hF, -1, got_bid, got_bresp);
    chk("t4_bad_burst_bresp", got_bresp, 2'b10);
    exp_d[0] = 32'hCAFE_F00D;
    do_read(4'd0, 32'h200, 8'd0, 2'b01, -1);
    chk("t4_no_proto_err_yet", proto_err, 0);
    exp_d[0] = 32'h55AA_55AA; exp_r[0] = 2'b00;
    exp_d[1] = 32'h0;         exp_r[1] = 2'b10;
    do_read(4'd9, 32'hFFC, 8'd1, 2'b01, -1);
    chk("t4_4k_proto_err", proto_err, 1);

    // Reset clears flag; memory contents survive
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    chk("rst2_proto_err", proto_err, 0);
    chk("rst2_awready", awready, 0);
    areset = 1'b0;
    @(negedge aclk);

    // 5: stall mid-burst with RD_WAIT=2
    exp_d[0] = 32'hD000_0001; exp_d[1] = 32'hD000_0002;
    exp_d[2] = 32'hD000_0003; exp_d[3] = 32'hD000_0000;
    for (int i = 0; i < 4; i++) exp_r[i] = 2'b00;
    do_read(4'd4, 32'h100, 8'd3, 2'b01, 1);

    // 6: early wlast
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h3000_0000 + 32'(i);
    do_write(4'd3, 32'h300, 8'd3, 2'b01, 4'hF, 1, got_bid, got_bresp);
    chk("t6_bresp", got_bresp, 2'b10);
    chk("t6_proto_err", proto_err, 1);
    exp_d[0] = 32'h3000_0003; exp_r[0] = 2'b00;
    do_read(4'd3, 32'h30C, 8'd0, 2'b01, -1);
    chk("t6_proto_err_sticky", proto_err, 1);

    // 6b: reset during a read burst
    @(negedge aclk);
    arid = 4'd8; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b0;
    t = 0;
    while (!arready && t < LIM) begin @(negedge aclk); t++; end
    chk("t6_ar_wait", t < LIM, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < LIM) begin @(negedge aclk); t++; end
    chk("t6_rvalid_before_reset", rvalid, 1);
    chk("t6_rdata_before_reset", rdata, 32'hD000_0001);
    areset = 1'b1;
    @(negedge aclk);
    chk("t6_rvalid_after_reset", rvalid, 0);
    chk("t6_rdata_after_reset", rdata, 0);
    chk("t6_proto_err_after_reset", proto_err, 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("t6_arready_after_reset", arready, 1);
    exp_d[0] = 32'hD000_0002; exp_d[1] = 32'hD000_0003;
    exp_r[0] = 2'b00;         exp_r[1] = 2'b00;
    do_read(4'd4, 32'h104, 8'd1, 2'b01, -1);
    wbuf[0] = 32'h7777_0000;
    do_write(4'd2, 32'h3F0, 8'd0, 2'b01, 4'hF, -1, got_bid, got_bresp);
    chk("t6_post_reset_bresp", got_bresp, 2'b00);
    chk("t6_post_reset_bid", got_bid, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
